// File: rtl/tnn_infer_ctrl.sv
// Frame loader and result handshake around a combinational ternary classifier:
// collects up to eight 2-bit features, lets the classifier settle, then holds one result.
//
// state  | meaning
// LOAD   | accepting feature beats into the slot register
// SETTLE | slots frozen on core_feat, waiting for the classifier output to settle
// RESULT | holding res_data/res_err until res_ready
module tnn_infer_ctrl #(
    parameter int SETTLE_CYCLES = 1,
    parameter int CNT_W         = 16
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             feat_valid,
    input  logic [1:0]       feat_data,
    input  logic             feat_last,
    output logic             feat_ready,
    output logic [15:0]      core_feat,
    input  logic             core_out,
    output logic             res_valid,
    output logic             res_data,
    output logic             res_err,
    input  logic             res_ready,
    input  logic             stats_clr,
    output logic [CNT_W-1:0] pos_count,
    output logic [CNT_W-1:0] tot_count
);

    typedef enum logic [1:0] {
        LOAD   = 2'd0,
        SETTLE = 2'd1,
        RESULT = 2'd2
    } state_t;

    localparam logic [3:0]       SETTLE_INIT = 4'(SETTLE_CYCLES - 1);
    localparam logic [CNT_W-1:0] CNT_MAX     = '1;

    state_t      state, state_nxt;
    logic [2:0]  idx;
    logic [15:0] slots;
    logic [3:0]  settle_cnt;
    logic        beat_acc;
    logic        frame_end;
    logic        settle_done;
    logic        handshake;

    assign core_feat = slots;

    always_ff @(posedge clk) begin
        if (rst) begin
            state <= LOAD;
        end else begin
            state <= state_nxt;
        end
    end

    always_comb begin
        state_nxt   = state;
        feat_ready  = 1'b0;
        res_valid   = 1'b0;
        beat_acc    = 1'b0;
        frame_end   = 1'b0;
        settle_done = 1'b0;
        handshake   = 1'b0;
        case (state)
            LOAD: begin
                feat_ready = 1'b1;
                beat_acc   = feat_valid;
                frame_end  = feat_valid && (feat_last || idx == 3'd7);
                if (frame_end) begin
                    state_nxt = SETTLE;
                end
            end
            SETTLE: begin
                settle_done = (settle_cnt == 4'd0);
                if (settle_done) begin
                    state_nxt = RESULT;
                end
            end
            RESULT: begin
                res_valid = 1'b1;
                handshake = res_ready;
                if (handshake) begin
                    state_nxt = LOAD;
                end
            end
            default: state_nxt = LOAD;
        endcase
    end

    // Frame is well formed only when feat_last lands exactly on the eighth beat.
    always_ff @(posedge clk) begin
        if (rst) begin
            idx        <= 3'd0;
            slots      <= '0;
            settle_cnt <= 4'd0;
            res_data   <= 1'b0;
            res_err    <= 1'b0;
        end else begin
            if (beat_acc) begin
                slots[{idx, 1'b0} +: 2] <= feat_data;
                idx <= frame_end ? 3'd0 : idx + 3'd1;
            end
            if (frame_end) begin
                res_err    <= !(feat_last && idx == 3'd7);
                settle_cnt <= SETTLE_INIT;
            end else if (state == SETTLE && !settle_done) begin
                settle_cnt <= settle_cnt - 4'd1;
            end
            if (settle_done) begin
                res_data <= core_out;
            end
            if (handshake) begin
                slots <= '0;
            end
        end
    end

    // Clear beats a coincident handshake; counters stick at all-ones.
    always_ff @(posedge clk) begin
        if (rst || stats_clr) begin
            pos_count <= '0;
            tot_count <= '0;
        end else if (handshake) begin
            if (tot_count != CNT_MAX) begin
                tot_count <= tot_count + CNT_W'(1);
            end
            if (res_data && pos_count != CNT_MAX) begin
                pos_count <= pos_count + CNT_W'(1);
            end
        end
    end

endmodule

// File: tb/tb_tnn_infer_ctrl.sv
// Directed bench for tnn_infer_ctrl: frame shapes, latency, backpressure,
// counter saturation/clear and reset recovery.
module tb_tnn_infer_ctrl;

    localparam int S  = 3;
    localparam int CW = 2;

    logic          clk = 1'b0;
    logic          rst;
    logic          feat_valid;
    logic [1:0]    feat_data;
    logic          feat_last;
    logic          feat_ready;
    logic [15:0]   core_feat;
    logic          core_out;
    logic          res_valid;
    logic          res_data;
    logic          res_err;
    logic          res_ready;
    logic          stats_clr;
    logic [CW-1:0] pos_count;
    logic [CW-1:0] tot_count;

    int total = 0;
    int bad   = 0;

    tnn_infer_ctrl #(.SETTLE_CYCLES(S), .CNT_W(CW)) dut (
        .clk        (clk),
        .rst        (rst),
        .feat_valid (feat_valid),
        .feat_data  (feat_data),
        .feat_last  (feat_last),
        .feat_ready (feat_ready),
        .core_feat  (core_feat),
        .core_out   (core_out),
        .res_valid  (res_valid),
        .res_data   (res_data),
        .res_err    (res_err),
        .res_ready  (res_ready),
        .stats_clr  (stats_clr),
        .pos_count  (pos_count),
        .tot_count  (tot_count)
    );

    always #5 clk = ~clk;

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic send_frame(input logic [15:0] vals, input int n, input logic last);
        for (int i = 0; i < n; i++) begin
            feat_valid = 1'b1;
            feat_data  = vals[2*i +: 2];
            feat_last  = last && (i == n - 1);
            tick();
        end
        feat_valid = 1'b0;
        feat_last  = 1'b0;
        feat_data  = 2'd0;
    endtask

    task automatic wait_res(output int cyc);
        cyc = 0;
        while (res_valid !== 1'b1 && cyc < 20) begin
            tick();
            cyc++;
        end
    endtask

    task automatic do_handshake();
        res_ready = 1'b1;
        tick();
        res_ready = 1'b0;
    endtask

    task automatic do_reset();
        rst = 1'b1;
        tick();
        tick();
        rst = 1'b0;
    endtask

    task automatic test_reset();
        do_reset();
        total++;
        if (core_feat !== 16'h0000 || feat_ready !== 1'b1 || res_valid !== 1'b0) begin
            bad++;
            $display("FAIL reset_ctrl: core_feat=%h feat_ready=%b res_valid=%b want 0000/1/0",
                     core_feat, feat_ready, res_valid);
        end
        total++;
        if (res_data !== 1'b0 || res_err !== 1'b0 || pos_count !== 2'd0 || tot_count !== 2'd0) begin
            bad++;
            $display("FAIL reset_res: res_data=%b res_err=%b pos=%0d tot=%0d want 0/0/0/0",
                     res_data, res_err, pos_count, tot_count);
        end
    endtask

    task automatic test_full_frame();
        int cyc;
        core_out = 1'b1;
        send_frame(16'h1B1B, 8, 1'b1);
        total++;
        if (core_feat !== 16'h1B1B || feat_ready !== 1'b0) begin
            bad++;
            $display("FAIL full_load: core_feat=%h feat_ready=%b want 1b1b/0", core_feat, feat_ready);
        end
        wait_res(cyc);
        total++;
        if (cyc !== S) begin
            bad++;
            $display("FAIL full_latency: got %0d edges want %0d", cyc, S);
        end
        total++;
        if (res_data !== 1'b1 || res_err !== 1'b0 || tot_count !== 2'd0) begin
            bad++;
            $display("FAIL full_result: res_data=%b res_err=%b tot=%0d want 1/0/0",
                     res_data, res_err, tot_count);
        end
        do_handshake();
        total++;
        if (pos_count !== 2'd1 || tot_count !== 2'd1) begin
            bad++;
            $display("FAIL full_counts: pos=%0d tot=%0d want 1/1", pos_count, tot_count);
        end
        total++;
        if (feat_ready !== 1'b1 || res_valid !== 1'b0 || core_feat !== 16'h0000) begin
            bad++;
            $display("FAIL full_return: feat_ready=%b res_valid=%b core_feat=%h want 1/0/0000",
                     feat_ready, res_valid, core_feat);
        end
    endtask

    task automatic test_short_frame();
        int cyc;
        core_out = 1'b0;
        send_frame(16'h0015, 3, 1'b1);
        total++;
        if (core_feat !== 16'h0015) begin
            bad++;
            $display("FAIL short_load: core_feat=%h want 0015", core_feat);
        end
        res_ready = 1'b1;
        wait_res(cyc);
        total++;
        if (cyc !== S || tot_count !== 2'd1) begin
            bad++;
            $display("FAIL short_settle: edges=%0d tot=%0d want %0d/1", cyc, tot_count, S);
        end
        total++;
        if (res_err !== 1'b1 || res_data !== 1'b0) begin
            bad++;
            $display("FAIL short_result: res_err=%b res_data=%b want 1/0", res_err, res_data);
        end
        tick();
        res_ready = 1'b0;
        total++;
        if (tot_count !== 2'd2 || pos_count !== 2'd1) begin
            bad++;
            $display("FAIL short_counts: pos=%0d tot=%0d want 1/2", pos_count, tot_count);
        end
    endtask

    task automatic test_missing_last();
        int cyc;
        stats_clr = 1'b1;
        tick();
        stats_clr = 1'b0;
        total++;
        if (pos_count !== 2'd0 || tot_count !== 2'd0) begin
            bad++;
            $display("FAIL clr_idle: pos=%0d tot=%0d want 0/0", pos_count, tot_count);
        end
        core_out = 1'b1;
        send_frame(16'hA5C3, 8, 1'b0);
        total++;
        if (feat_ready !== 1'b0 || core_feat !== 16'hA5C3) begin
            bad++;
            $display("FAIL nolast_end: feat_ready=%b core_feat=%h want 0/a5c3", feat_ready, core_feat);
        end
        feat_valid = 1'b1;
        feat_data  = 2'd3;
        wait_res(cyc);
        total++;
        if (cyc !== S || res_err !== 1'b1 || res_data !== 1'b1 || core_feat !== 16'hA5C3) begin
            bad++;
            $display("FAIL nolast_result: edges=%0d res_err=%b res_data=%b core_feat=%h want %0d/1/1/a5c3",
                     cyc, res_err, res_data, core_feat, S);
        end
        do_handshake();
        total++;
        if (core_feat !== 16'h0000 || feat_ready !== 1'b1) begin
            bad++;
            $display("FAIL ninth_beat_hs: core_feat=%h feat_ready=%b want 0000/1", core_feat, feat_ready);
        end
        feat_last = 1'b1;
        tick();
        feat_valid = 1'b0;
        feat_last  = 1'b0;
        feat_data  = 2'd0;
        total++;
        if (core_feat !== 16'h0003 || feat_ready !== 1'b0) begin
            bad++;
            $display("FAIL ninth_beat_acc: core_feat=%h feat_ready=%b want 0003/0", core_feat, feat_ready);
        end
        wait_res(cyc);
        do_handshake();
        total++;
        if (tot_count !== 2'd2 || pos_count !== 2'd2) begin
            bad++;
            $display("FAIL nolast_counts: pos=%0d tot=%0d want 2/2", pos_count, tot_count);
        end
    endtask

    task automatic test_backpressure();
        int cyc;
        logic [CW-1:0] exp_cnt;
        core_out = 1'b1;
        send_frame(16'h3C96, 8, 1'b1);
        wait_res(cyc);
        total++;
        if (cyc !== S) begin
            bad++;
            $display("FAIL bp_latency: got %0d edges want %0d", cyc, S);
        end
        res_ready  = 1'b0;
        feat_valid = 1'b1;
        feat_data  = 2'd2;
        core_out   = 1'b0;
        for (int i = 0; i < 10; i++) begin
            stats_clr = (i == 4);
            tick();
            exp_cnt = (i < 4) ? 2'd2 : 2'd0;
            total++;
            if (res_valid !== 1'b1 || res_data !== 1'b1 || core_feat !== 16'h3C96 ||
                feat_ready !== 1'b0 || tot_count !== exp_cnt || pos_count !== exp_cnt) begin
                bad++;
                $display("FAIL bp_hold[%0d]: valid=%b data=%b feat=%h ready=%b pos=%0d tot=%0d want 1/1/3c96/0/%0d/%0d",
                         i, res_valid, res_data, core_feat, feat_ready, pos_count, tot_count,
                         exp_cnt, exp_cnt);
            end
        end
        stats_clr  = 1'b0;
        feat_valid = 1'b0;
        feat_data  = 2'd0;
        do_handshake();
        total++;
        if (tot_count !== 2'd1 || pos_count !== 2'd1) begin
            bad++;
            $display("FAIL bp_counts: pos=%0d tot=%0d want 1/1", pos_count, tot_count);
        end
    endtask

    task automatic test_saturation();
        int cyc;
        logic [CW-1:0] exp_cnt;
        stats_clr = 1'b1;
        tick();
        stats_clr = 1'b0;
        core_out  = 1'b1;
        for (int f = 1; f <= 5; f++) begin
            send_frame(16'hFFFF, 8, 1'b1);
            wait_res(cyc);
            do_handshake();
            exp_cnt = (f >= 3) ? 2'd3 : CW'(f);
            total++;
            if (pos_count !== exp_cnt || tot_count !== exp_cnt) begin
                bad++;
                $display("FAIL sat[%0d]: pos=%0d tot=%0d want %0d/%0d",
                         f, pos_count, tot_count, exp_cnt, exp_cnt);
            end
        end
        send_frame(16'hFFFF, 8, 1'b1);
        wait_res(cyc);
        stats_clr = 1'b1;
        do_handshake();
        stats_clr = 1'b0;
        total++;
        if (pos_count !== 2'd0 || tot_count !== 2'd0 || feat_ready !== 1'b1) begin
            bad++;
            $display("FAIL clr_hs: pos=%0d tot=%0d feat_ready=%b want 0/0/1",
                     pos_count, tot_count, feat_ready);
        end
    endtask

    task automatic test_reset_recovery();
        int cyc;
        send_frame(16'h00FF, 4, 1'b0);
        total++;
        if (core_feat !== 16'h00FF || feat_ready !== 1'b1) begin
            bad++;
            $display("FAIL mid_load: core_feat=%h feat_ready=%b want 00ff/1", core_feat, feat_ready);
        end
        do_reset();
        total++;
        if (core_feat !== 16'h0000 || feat_ready !== 1'b1) begin
            bad++;
            $display("FAIL mid_reset: core_feat=%h feat_ready=%b want 0000/1", core_feat, feat_ready);
        end
        core_out = 1'b0;
        send_frame(16'h1B1B, 8, 1'b1);
        total++;
        if (core_feat !== 16'h1B1B || feat_ready !== 1'b0) begin
            bad++;
            $display("FAIL post_reset_frame: core_feat=%h feat_ready=%b want 1b1b/0", core_feat, feat_ready);
        end
        wait_res(cyc);
        total++;
        if (cyc !== S || res_err !== 1'b0) begin
            bad++;
            $display("FAIL post_reset_res: edges=%0d res_err=%b want %0d/0", cyc, res_err, S);
        end
        do_handshake();
        total++;
        if (tot_count !== 2'd1 || pos_count !== 2'd0) begin
            bad++;
            $display("FAIL post_reset_counts: pos=%0d tot=%0d want 0/1", pos_count, tot_count);
        end
        core_out = 1'b1;
        send_frame(16'h0015, 3, 1'b1);
        wait_res(cyc);
        do_reset();
        total++;
        if (res_valid !== 1'b0 || res_data !== 1'b0 || res_err !== 1'b0 || tot_count !== 2'd0 ||
            core_feat !== 16'h0000) begin
            bad++;
            $display("FAIL result_reset: valid=%b data=%b err=%b tot=%0d feat=%h want 0/0/0/0/0000",
                     res_valid, res_data, res_err, tot_count, core_feat);
        end
    endtask

    initial begin
        rst        = 1'b1;
        feat_valid = 1'b0;
        feat_data  = 2'd0;
        feat_last  = 1'b0;
        core_out   = 1'b0;
        res_ready  = 1'b0;
        stats_clr  = 1'b0;
        test_reset();
        test_full_frame();
        test_short_frame();
        test_missing_last();
        test_backpressure();
        test_saturation();
        test_reset_recovery();
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule

// File: doc/tnn_infer_ctrl.md
TNN_INFER_CTRL -- requirements
Module: tnn_infer_ctrl

Interface
REQ-001 Parameter SETTLE_CYCLES, default 1, sets the cycles the feature vector is held on the classifier before sampling; legal range 1..15.
REQ-002 Parameter CNT_W, default 16, sets the width of the statistics counters.
REQ-003 The block SHALL use a single clock, clk; every register SHALL update on the rising edge of clk.
REQ-004 rst SHALL be a synchronous, active-high reset.
REQ-005 Ports SHALL be exactly as follows:
- clk  in  1  clock
- rst  in  1  synchronous active-high reset
- feat_valid  in  1  feature beat valid
- feat_data  in  2  one 2-bit feature
- feat_last  in  1  final beat of frame
- feat_ready  out  1  beat accepted when high with feat_valid
- core_feat  out  16  to classifier; [1:0]=input_a ... [15:14]=input_h
- core_out  in  1  classifier cgp_out (combinational)
- res_valid  out  1  result available
- res_data  out  1  captured class bit
- res_err  out  1  frame length error for this result
- res_ready  in  1  result consumed when high with res_valid
- stats_clr  in  1  clear counters
- pos_count  out  CNT_W  results with res_data=1
- tot_count  out  CNT_W  total results delivered

Function
REQ-006 The FSM SHALL have three states: LOAD, SETTLE, RESULT.
REQ-007 feat_ready SHALL be 1 only in LOAD; res_valid SHALL be 1 only in RESULT.
REQ-008 In LOAD, each accepted beat SHALL write feat_data into slot idx (bits 2*idx+1:2*idx) and increment a 3-bit idx, starting from idx=0.
REQ-009 A frame SHALL end on the beat with feat_last=1 or on the beat at idx=7, whichever occurs first; the FSM SHALL then go to SETTLE with idx=0.
REQ-010 res_err for a frame SHALL be 1 iff feat_last and idx=7 do not coincide on the ending beat, covering both a short frame and a missing last.
REQ-011 Slots not written in a short frame SHALL read 00.
REQ-012 All slots SHALL be cleared to 00 on the transition from RESULT to LOAD.
REQ-013 core_feat SHALL be driven directly from the slot register and SHALL NOT change outside LOAD.
REQ-014 SETTLE SHALL last exactly SETTLE_CYCLES cycles.
REQ-015 On the final SETTLE edge, core_out SHALL be registered into res_data and the FSM SHALL go to RESULT.
REQ-016 Latency: if the ending beat is accepted at edge k, res_valid SHALL be 1 after edge k+SETTLE_CYCLES.
REQ-017 In RESULT, res_valid, res_data and res_err SHALL hold stable until res_ready=1.
REQ-018 On the handshake edge the FSM SHALL return to LOAD; feat_ready SHALL be 1 in the next cycle, so there is no same-cycle beat acceptance.
REQ-019 On each result handshake, tot_count SHALL increment by 1, and pos_count SHALL increment by 1 if res_data=1.
REQ-020 Both counters SHALL saturate at 2^CNT_W-1 and SHALL NOT wrap.
REQ-021 stats_clr SHALL zero both counters at the next edge.
REQ-022 If stats_clr coincides with a handshake, the clear SHALL win and both counters SHALL be 0.
REQ-023 stats_clr SHALL NOT affect the FSM, the slots or the result registers.
REQ-024 feat_valid SHALL be ignored outside LOAD.
REQ-025 res_ready SHALL be ignored outside RESULT.

Reset
REQ-026 While rst=1 the block SHALL go to LOAD with idx=0.
REQ-027 While rst=1 all slots SHALL be cleared, so core_feat=0.
REQ-028 While rst=1 res_data, res_err, res_valid, pos_count and tot_count SHALL be 0, and feat_ready=1 after the reset edge.
REQ-029 Reset SHALL take priority over every other input, including mid-frame, in SETTLE and in RESULT; any partial frame or pending result SHALL be discarded and not counted.

Verification
REQ-030 Full frame: 8 beats of feature values 3,2,1,0,3,2,1,0 with feat_last on the 8th beat and core_out=1 -> core_feat=16'h1B1B, res_valid exactly SETTLE_CYCLES edges after the last beat, res_data=1, res_err=0, pos_count=1, tot_count=1.
REQ-031 Short frame: 3 beats of 1,1,1 with feat_last on the 3rd beat -> core_feat=16'h0015, res_err=1.
REQ-032 Missing last: 8 beats with feat_last=0 -> frame ends, res_err=1; the 9th beat is not accepted until after the result handshake.
REQ-033 Backpressure: res_ready=0 for 10 cycles -> res_valid, res_data and core_feat stay stable and feat_ready=0; the counters change only on the handshake.
REQ-034 Saturation and clear: with CNT_W=2, 5 positive results -> pos_count=3 and tot_count=3; stats_clr together with a handshake -> both counters 0.
REQ-035 Reset mid-frame after 4 beats, then a full frame -> tot_count=1 and no stale slot data appears on core_feat.
